serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// One operand bit pair is consumed per clock, LSB first. The result
// accumulates in a right-shifting sum register, so after WIDTH shifts the
// first-computed bit sits at bit 0. A three-state FSM (IDLE/SHIFT/DONE)
// sequences the operation. busy and done are decoded from the registered state.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Wide enough to hold WIDTH, so the count never wraps inside an operation.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_next;

    // Per-bit full-adder slice and control decode
    always_comb begin
        accept     = start && (state != SHIFT);
        last_bit   = (state == SHIFT) && (count == CW'(WIDTH - 1));
        sum_bit    = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle and may chain straight into SHIFT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on accept, otherwise shift one bit per SHIFT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            count <= '0;
        end else if (state == SHIFT) begin
            sum   <= {sum_bit, sum[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= carry_next;
            count <= count + CW'(1);
            if (last_bit) begin
                cout <= carry_next;
            end
        end
    end

    // Status outputs decoded from registered state
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

endmodule
